vga_sync_receiver: RTL and testbench
====================================

Name: vga_sync_receiver

Overview:
- Receive end of the 640x480@60 VGA link driven by the team's timing generator. Inputs are active-high sync pulses plus 1-bit R/G/B.
- Recovers pixel coordinates, measures line and frame length, and declares lock.
- Emits a pixel stream (x, y, rgb, valid) for frame-capture or self-check logic.
- Sits on the board loopback and verification path, clocked by the same 25 MHz pixel clock.

Parameters:
- H_TOTAL, 800: expected clocks per line.
- V_TOTAL, 525: expected lines per frame.
- H_ACT_START, 144: hsync width plus back porch, in clocks from hsync rise.
- H_ACT, 640: active pixels per line.
- V_ACT_START, 35: vsync width plus back porch, in lines from vsync rise.
- V_ACT, 480: active lines per frame.
- LOCK_FRAMES, 2: consecutive good frames required to declare lock.

Ports:
- clk  in  1  pixel clock, 25 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- vga_hsy  in  1  line sync, active high.
- vga_vsy  in  1  frame sync, active high.
- vga_r, vga_g, vga_b  in  1 each  pixel colour.
- pix_valid  out  1  active-area pixel, only while locked.
- pix_x  out  12  column 0..639.
- pix_y  out  12  row 0..479.
- pix_rgb  out  3  {r,g,b}.
- frame_start  out  1  one-cycle pulse on each vsync rise.
- h_meas  out  12  length of the last complete line, in clocks.
- v_meas  out  12  length of the last complete frame, in lines.
- locked  out  1  timing matches parameters.
- err  out  1  one-cycle pulse on a timing violation.

Behaviour:
- Reset: every output is 0 and every counter is 0. FSM enters UNLOCKED and clears h_seen.
- Input stage: hsy/vsy/rgb are registered once (stage S1), then registered again (S1d) for edge detection.
  - hs_rise = S1 & ~S1d; vs_rise likewise.
- hcnt (12b):
  - 0 on hs_rise; otherwise +1, saturating at 4095.
  - On hs_rise with h_seen=1: h_meas <= hcnt+1. Then h_seen <= 1.
- vcnt (12b):
  - 0 on vs_rise. vs_rise takes priority over a simultaneous hs_rise, which is the normal alignment.
  - Otherwise +1 on hs_rise, saturating at 4095.
  - On vs_rise: v_meas <= vcnt+1.
- Active window: H_ACT_START <= hcnt < H_ACT_START+H_ACT and V_ACT_START <= vcnt < V_ACT_START+V_ACT.
  - pix_x = hcnt-H_ACT_START; pix_y = vcnt-V_ACT_START.
- Pixel outputs:
  - pix_* registered from S1: 2-cycle latency from pins.
  - pix_valid = window & locked.
  - pix_x, pix_y and pix_rgb hold their last values when pix_valid is 0.
- frame_start: registered with the pix_* outputs, so aligned with pixel latency.
- Line error (line_bad): hs_rise with h_seen=1 and hcnt+1 != H_TOTAL, or hcnt reaching 4095 (sync loss).
- FSM states:
  - UNLOCKED: on vs_rise go to CHECKING; good_cnt=0, frame_bad=0.
  - CHECKING: line_bad sets frame_bad. On vs_rise:
    - if !frame_bad and vcnt+1==V_TOTAL: good_cnt+1; when it reaches LOCK_FRAMES go to LOCKED (locked=1 next cycle);
    - else good_cnt=0.
    - frame_bad clears at every vs_rise.
  - LOCKED: line_bad, or vs_rise with vcnt+1 != V_TOTAL, gives err=1 for one cycle, locked=0 and a return to UNLOCKED the same cycle. A violating vs_rise does not re-arm; the next vs_rise does.
- err never pulses outside LOCKED.
- Lock-loss cycle: pix_valid deasserts in the same registered cycle that locked falls.

Decomposition:
- Shared package vga_timing_pkg holds the 640x480 constants (totals, sync widths, porches, active sizes) and the FSM state enum. The timing generator and this receiver use the same numbers from it.
- One sub-module, vga_sync_edge: the 2-flop register plus rise detect, instantiated for hsync and vsync.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately; after release, locked=0 until the third vs_rise.
- Nominal lock: drive from the team generator -> h_meas=800 and v_meas=525; locked rises one cycle after the 3rd vs_rise; err stays 0.
- Pixel mapping: generator pattern r=x[0], g=y[0], b=x[1] -> per frame exactly 307200 pix_valid cycles.
  - First valid pixel is (0,0), last is (639,479).
  - pix_rgb matches the pattern at every valid pixel.
- Short line: while locked, one line of 799 clocks -> err pulse at that hs_rise; locked=0 and h_meas=799; relock after 3 further vs_rise.
- Sync loss: hold hsync low for 5000 clocks while locked -> err when hcnt hits 4095; locked=0; pix_valid=0.
- Bad frame: 526-line frame in CHECKING -> good_cnt resets; lock is delayed by one frame; no err pulse.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and receiver FSM state type.
package vga_timing_pkg;

  // Horizontal timing, in pixel clocks.
  localparam int unsigned VGA_H_SYNC      = 96;
  localparam int unsigned VGA_H_BACK      = 48;
  localparam int unsigned VGA_H_ACT       = 640;
  localparam int unsigned VGA_H_FRONT     = 16;
  localparam int unsigned VGA_H_TOTAL     = VGA_H_SYNC + VGA_H_BACK + VGA_H_ACT + VGA_H_FRONT;
  localparam int unsigned VGA_H_ACT_START = VGA_H_SYNC + VGA_H_BACK;

  // Vertical timing, in lines.
  localparam int unsigned VGA_V_SYNC      = 2;
  localparam int unsigned VGA_V_BACK      = 33;
  localparam int unsigned VGA_V_ACT       = 480;
  localparam int unsigned VGA_V_FRONT     = 10;
  localparam int unsigned VGA_V_TOTAL     = VGA_V_SYNC + VGA_V_BACK + VGA_V_ACT + VGA_V_FRONT;
  localparam int unsigned VGA_V_ACT_START = VGA_V_SYNC + VGA_V_BACK;

  // Consecutive good frames before the receiver declares lock.
  localparam int unsigned VGA_LOCK_FRAMES = 2;

  // Counter width and saturation value shared by the line/frame counters.
  localparam int unsigned CNT_W   = 12;
  localparam logic [11:0] CNT_MAX = 12'hFFF;

  typedef enum logic [1:0] {
    StUnlocked,
    StChecking,
    StLocked
  } rx_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop sync register with rising-edge detect.
module vga_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic rise
);

  logic s1_q;
  logic s1d_q;

  // First stage registers the pin, second stage holds it one more cycle for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q  <= 1'b0;
      s1d_q <= 1'b0;
    end else begin
      s1_q  <= sync_in;
      s1d_q <= s1_q;
    end
  end

  assign rise = s1_q & ~s1d_q;

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA receive end: recovers pixel coordinates, measures timing and tracks lock.
module vga_sync_receiver
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned H_ACT       = VGA_H_ACT,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START,
  parameter int unsigned V_ACT       = VGA_V_ACT,
  parameter int unsigned LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vga_hsy,
  input  logic        vga_vsy,
  input  logic        vga_r,
  input  logic        vga_g,
  input  logic        vga_b,
  output logic        pix_valid,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic [2:0]  pix_rgb,
  output logic        frame_start,
  output logic [11:0] h_meas,
  output logic [11:0] v_meas,
  output logic        locked,
  output logic        err
);

  logic        hs_rise;
  logic        vs_rise;
  logic [2:0]  rgb_s1_q;
  logic [11:0] hcnt_q;
  logic [11:0] vcnt_q;
  logic        h_seen_q;
  logic [11:0] hcnt_inc;
  logic [11:0] vcnt_inc;
  logic        line_bad;
  logic        frame_len_ok;
  logic        window;
  logic        valid_d;

  rx_state_e   state_q, state_d;
  logic [7:0]  good_q, good_d;
  logic [7:0]  good_inc;
  logic        frame_bad_q, frame_bad_d;
  logic        err_d;

  vga_sync_edge u_hs_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_in (vga_hsy),
    .rise    (hs_rise)
  );

  vga_sync_edge u_vs_edge (
    .clk     (clk),
    .rst_n   (rst_n),
    .sync_in (vga_vsy),
    .rise    (vs_rise)
  );

  // Colour gets the same first-stage register as the syncs so it stays aligned with hcnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_s1_q <= 3'b000;
    end else begin
      rgb_s1_q <= {vga_r, vga_g, vga_b};
    end
  end

  assign hcnt_inc     = hcnt_q + 12'd1;
  assign vcnt_inc     = vcnt_q + 12'd1;
  assign frame_len_ok = (vcnt_inc == 12'(V_TOTAL));
  // A counter stuck at its ceiling means hsync has gone away.
  assign line_bad     = (hs_rise && h_seen_q && (hcnt_inc != 12'(H_TOTAL))) ||
                        (hcnt_q == CNT_MAX);
  assign window       = (hcnt_q >= 12'(H_ACT_START)) &&
                        (hcnt_q <  12'(H_ACT_START + H_ACT)) &&
                        (vcnt_q >= 12'(V_ACT_START)) &&
                        (vcnt_q <  12'(V_ACT_START + V_ACT));

  // Line and frame counters plus the length measurements taken at each sync edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      h_seen_q <= 1'b0;
      h_meas   <= '0;
      v_meas   <= '0;
    end else begin
      if (hs_rise) begin
        hcnt_q   <= '0;
        h_seen_q <= 1'b1;
        if (h_seen_q) begin
          h_meas <= hcnt_inc;
        end
      end else if (hcnt_q != CNT_MAX) begin
        hcnt_q <= hcnt_inc;
      end
      // vsync normally lands with hsync; it wins so line 0 starts at zero.
      if (vs_rise) begin
        vcnt_q <= '0;
        v_meas <= vcnt_inc;
      end else if (hs_rise && (vcnt_q != CNT_MAX)) begin
        vcnt_q <= vcnt_inc;
      end
    end
  end

  assign good_inc = good_q + 8'd1;

  // Lock FSM next-state: qualify whole frames, then watch for any violation while locked.
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    frame_bad_d = frame_bad_q;
    err_d       = 1'b0;
    unique case (state_q)
      StUnlocked: begin
        if (vs_rise) begin
          state_d     = StChecking;
          good_d      = '0;
          frame_bad_d = 1'b0;
        end
      end
      StChecking: begin
        if (line_bad) begin
          frame_bad_d = 1'b1;
        end
        if (vs_rise) begin
          frame_bad_d = 1'b0;
          if (!frame_bad_q && !line_bad && frame_len_ok) begin
            good_d = good_inc;
            if (good_inc >= 8'(LOCK_FRAMES)) begin
              state_d = StLocked;
            end
          end else begin
            good_d = '0;
          end
        end
      end
      StLocked: begin
        if (line_bad || (vs_rise && !frame_len_ok)) begin
          err_d   = 1'b1;
          state_d = StUnlocked;
        end
      end
      default: begin
        state_d = StUnlocked;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StUnlocked;
      good_q      <= '0;
      frame_bad_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      good_q      <= good_d;
      frame_bad_q <= frame_bad_d;
    end
  end

  assign locked = (state_q == StLocked);

  // Use next-state lock so pix_valid drops in the same cycle locked does.
  assign valid_d = window && (state_d == StLocked);

  // Registered pixel stream; coordinates and colour hold outside valid pixels.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      pix_valid   <= valid_d;
      frame_start <= vs_rise;
      err         <= err_d;
      if (valid_d) begin
        pix_x   <= hcnt_q - 12'(H_ACT_START);
        pix_y   <= vcnt_q - 12'(V_ACT_START);
        pix_rgb <= rgb_s1_q;
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Self-checking bench for vga_sync_receiver using a scaled-down timing set.
module tb_vga_sync_receiver;

  // Scaled timing keeps a frame at 640 clocks; sync widths are bench-side generator choices.
  localparam int HT  = 40;
  localparam int HSW = 4;
  localparam int HAS = 8;
  localparam int HA  = 24;
  localparam int VT  = 16;
  localparam int VSW = 2;
  localparam int VAS = 3;
  localparam int VA  = 10;
  localparam int LF  = 2;
  localparam int FULL_PIX = HA * VA;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_hsy = 1'b0;
  logic        vga_vsy = 1'b0;
  logic        vga_r = 1'b0;
  logic        vga_g = 1'b0;
  logic        vga_b = 1'b0;
  logic        pix_valid;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic [2:0]  pix_rgb;
  logic        frame_start;
  logic [11:0] h_meas;
  logic [11:0] v_meas;
  logic        locked;
  logic        err;

  int checks = 0;
  int errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int exp_x = 0;
  int exp_y = 0;
  int last_x = -1;
  int last_y = -1;

  logic        snap_lock_b, snap_lock_a, snap_fs_b, snap_fs_a;
  logic [11:0] snap_vmeas, snap_hmeas;
  logic [11:0] line_hm, short_hmeas;
  logic        line_err, short_err;

  typedef struct {
    int nlines;
    int short_line;
    int lock_b;
    int lock_a;
    int vmeas;
    int hmeas;
    int errs;
    int pixels;
  } frame_vec_t;

  frame_vec_t tbl[12];

  vga_sync_receiver #(
    .H_TOTAL     (HT),
    .V_TOTAL     (VT),
    .H_ACT_START (HAS),
    .H_ACT       (HA),
    .V_ACT_START (VAS),
    .V_ACT       (VA),
    .LOCK_FRAMES (LF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_hsy     (vga_hsy),
    .vga_vsy     (vga_vsy),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .pix_valid   (pix_valid),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_rgb     (pix_rgb),
    .frame_start (frame_start),
    .h_meas      (h_meas),
    .v_meas      (v_meas),
    .locked      (locked),
    .err         (err)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Test pattern: r = x[0], g = y[0], b = x[1].
  function automatic logic [2:0] pattern(input int x, input int y);
    logic [11:0] xv;
    logic [11:0] yv;
    xv = 12'(x);
    yv = 12'(y);
    return {xv[0], yv[0], xv[1]};
  endfunction

  // One generator line. The receiver's column origin is the clock after the hsync rise,
  // so column x is driven at clock x + 1 + HAS of the line.
  task automatic drive_line(input int len, input int gv);
    int px;
    int py;
    for (int gh = 0; gh < len; gh++) begin
      @(negedge clk);
      if (gv == 0 && gh == 1) begin
        snap_lock_b = locked;
        snap_fs_b   = frame_start;
      end
      if (gv == 0 && gh == 2) begin
        snap_lock_a = locked;
        snap_fs_a   = frame_start;
        snap_vmeas  = v_meas;
        snap_hmeas  = h_meas;
      end
      if (gh == 2) begin
        line_hm  = h_meas;
        line_err = err;
      end
      vga_hsy = (gh < HSW);
      vga_vsy = (gv < VSW);
      px = gh - 1 - HAS;
      py = gv - VAS;
      if (px >= 0 && px < HA && py >= 0 && py < VA) begin
        {vga_r, vga_g, vga_b} = pattern(px, py);
      end else begin
        {vga_r, vga_g, vga_b} = 3'($urandom);
      end
    end
  endtask

  task automatic drive_frame(input int nlines, input int short_line);
    for (int l = 0; l < nlines; l++) begin
      drive_line((l == short_line) ? HT - 1 : HT, l);
      if (short_line >= 0 && l == short_line + 1) begin
        short_hmeas = line_hm;
        short_err   = line_err;
      end
    end
  endtask

  // Scoreboard: valid pixels must arrive in raster order with the pattern colour.
  always @(posedge clk) begin
    #1;
    if (err) err_cnt++;
    if (frame_start) begin
      exp_x = 0;
      exp_y = 0;
    end
    if (pix_valid) begin
      valid_cnt++;
      chk("valid_implies_locked", int'(locked), 1);
      chk("pix_x", int'(pix_x), exp_x);
      chk("pix_y", int'(pix_y), exp_y);
      chk("pix_rgb", int'(pix_rgb), int'(pattern(exp_x, exp_y)));
      last_x = int'(pix_x);
      last_y = int'(pix_y);
      exp_x++;
      if (exp_x == HA) begin
        exp_x = 0;
        exp_y++;
      end
    end
  end

  initial begin
    int sl;
    int first_err;

    sl = VAS + int'($urandom_range(0, VA - 1));
    //           nlines  short  lk_b lk_a vmeas  hmeas errs pixels
    tbl[0]  = '{VT,     -1,    0,   0,   1,     0,    0,   0};
    tbl[1]  = '{VT,     -1,    0,   0,   VT,    HT,   0,   0};
    tbl[2]  = '{VT,     -1,    0,   1,   VT,    HT,   0,   FULL_PIX};
    tbl[3]  = '{VT,     sl,    1,   1,   VT,    HT,   1,   (sl - VAS + 1) * HA};
    tbl[4]  = '{VT,     -1,    0,   0,   VT,    HT,   0,   0};
    tbl[5]  = '{VT,     -1,    0,   0,   VT,    HT,   0,   0};
    tbl[6]  = '{VT + 1, -1,    0,   1,   VT,    HT,   0,   FULL_PIX};
    tbl[7]  = '{VT,     -1,    1,   0,   VT + 1, HT,  1,   0};
    tbl[8]  = '{VT + 1, -1,    0,   0,   VT,    HT,   0,   0};
    tbl[9]  = '{VT,     -1,    0,   0,   VT + 1, HT,  0,   0};
    tbl[10] = '{VT,     -1,    0,   0,   VT,    HT,   0,   0};
    tbl[11] = '{VT,     -1,    0,   1,   VT,    HT,   0,   FULL_PIX};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst pix_valid", int'(pix_valid), 0);
    chk("rst pix_x", int'(pix_x), 0);
    chk("rst frame_start", int'(frame_start), 0);
    chk("rst h_meas", int'(h_meas), 0);
    chk("rst v_meas", int'(v_meas), 0);
    chk("rst locked", int'(locked), 0);
    chk("rst err", int'(err), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      valid_cnt = 0;
      err_cnt   = 0;
      last_x    = -1;
      last_y    = -1;
      drive_frame(tbl[i].nlines, tbl[i].short_line);
      chk($sformatf("f%0d frame_start_before", i), int'(snap_fs_b), 0);
      chk($sformatf("f%0d frame_start", i), int'(snap_fs_a), 1);
      chk($sformatf("f%0d locked_before", i), int'(snap_lock_b), tbl[i].lock_b);
      chk($sformatf("f%0d locked_after", i), int'(snap_lock_a), tbl[i].lock_a);
      chk($sformatf("f%0d v_meas", i), int'(snap_vmeas), tbl[i].vmeas);
      chk($sformatf("f%0d h_meas", i), int'(snap_hmeas), tbl[i].hmeas);
      chk($sformatf("f%0d err_pulses", i), err_cnt, tbl[i].errs);
      chk($sformatf("f%0d valid_pixels", i), valid_cnt, tbl[i].pixels);
      if (tbl[i].pixels == FULL_PIX) begin
        chk($sformatf("f%0d last_x", i), last_x, HA - 1);
        chk($sformatf("f%0d last_y", i), last_y, VA - 1);
      end
      if (tbl[i].short_line >= 0) begin
        chk("short h_meas", int'(short_hmeas), HT - 1);
        chk("short err_at_rise", int'(short_err), 1);
      end
    end

    // Sync loss: hsync stops after a locked frame.
    valid_cnt = 0;
    err_cnt   = 0;
    drive_frame(VT, -1);
    chk("preloss locked", int'(locked), 1);
    chk("preloss pixels", valid_cnt, FULL_PIX);
    valid_cnt = 0;
    err_cnt   = 0;
    first_err = -1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (err && first_err < 0) first_err = i;
      vga_hsy = 1'b0;
      vga_vsy = 1'b0;
      {vga_r, vga_g, vga_b} = 3'($urandom);
    end
    chk("loss err_pulses", err_cnt, 1);
    // Last hsync rise was 40 clocks before the loss window; hcnt saturates 4095 clocks later.
    chk("loss err_cycle", first_err, 4096 + 2 - HT);
    chk("loss locked", int'(locked), 0);
    chk("loss valid_pixels", valid_cnt, 0);

    // Relock after the loss, then reset mid-line while pixels are flowing.
    err_cnt = 0;
    for (int f = 0; f < 3; f++) drive_frame(VT, -1);
    chk("relock locked_before", int'(snap_lock_b), 0);
    chk("relock locked_after", int'(snap_lock_a), 1);
    chk("relock err_pulses", err_cnt, 0);
    for (int l = 0; l < VAS + 2; l++) drive_line(HT, l);
    drive_line(HAS + 12, VAS + 2);
    chk("prerst pix_valid", int'(pix_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst pix_valid", int'(pix_valid), 0);
    chk("midrst pix_x", int'(pix_x), 0);
    chk("midrst pix_y", int'(pix_y), 0);
    chk("midrst pix_rgb", int'(pix_rgb), 0);
    chk("midrst h_meas", int'(h_meas), 0);
    chk("midrst v_meas", int'(v_meas), 0);
    chk("midrst locked", int'(locked), 0);
    chk("midrst err", int'(err), 0);
    chk("midrst frame_start", int'(frame_start), 0);
    repeat (3) begin
      @(negedge clk);
      {vga_hsy, vga_vsy, vga_r, vga_g, vga_b} = 5'b00000;
    end
    rst_n = 1'b1;
    for (int f = 0; f < 3; f++) begin
      drive_frame(VT, -1);
      chk($sformatf("postrst vs%0d locked", f + 1), int'(snap_lock_a), (f == 2) ? 1 : 0);
    end
    chk("postrst err_pulses", err_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
